// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - eight-digit multiplexed hex display driver with blank interval per slot
// Optional leading-zero suppression: define SEG7_LZ_BLANK_EN.
module seg7_scan_display #(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_in,
   input  logic        load,
   input  logic [7:0]  dp_in,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   logic [31:0]      word_q, word_d;
   logic [7:0]       dpreq_q, dpreq_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic [3:0]       nibble;
   logic             in_blank;
   logic             digit_on;
   logic             slot_end;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

`ifdef SEG7_LZ_BLANK_EN
   logic [2:0] top_digit;

   // Highest nonzero nibble; digit 0 is always at or below it, so "0" still shows.
   always_comb begin
      top_digit = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (word_q[4*i +: 4] != 4'h0) top_digit = 3'(i);
      end
      digit_on = (idx_q <= top_digit) || dpreq_q[idx_q];
   end
`else
   always_comb digit_on = 1'b1;
`endif

   always_comb begin
      word_d   = load ? data_in : word_q;
      dpreq_d  = load ? dp_in : dpreq_q;

      slot_end = (div_q == DIV_LAST);
      div_d    = slot_end ? '0 : div_q + DIV_W'(1);
      idx_d    = slot_end ? idx_q + 3'd1 : idx_q;

      nibble   = word_q[{idx_q, 2'b00} +: 4];
      in_blank = (32'(div_q) < BLANK_CYCLES);

      if (in_blank || !digit_on) begin
         an_d  = 8'hFF;
         seg_d = 7'h7F;
         dp_d  = 1'b1;
      end else begin
         an_d  = ~(8'b1 << idx_q);
         seg_d = hex_to_seg(nibble);
         dp_d  = ~dpreq_q[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q  <= '0;
         dpreq_q <= '0;
         div_q   <= '0;
         idx_q   <= '0;
         an_q    <= 8'hFF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
      end else begin
         word_q  <= word_d;
         dpreq_q <= dpreq_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - scoreboard bench for seg7_scan_display (REFRESH_DIV=4, BLANK_CYCLES=1)
// Build with SEG7_LZ_BLANK_EN defined to exercise leading-zero suppression.
module tb_seg7_scan_display;

   localparam int RDIV  = 4;
   localparam int BLANK = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_in;
   logic        load;
   logic [7:0]  dp_in;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   seg7_scan_display #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK)) dut (
      .clk     (clk),
      .rst     (rst),
      .data_in (data_in),
      .load    (load),
      .dp_in   (dp_in),
      .an      (an),
      .seg     (seg),
      .dp      (dp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] val;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Expected display contents, set by hand after each load.
   logic [55:0] exp_segs;
   logic [7:0]  exp_mask;
   logic [7:0]  exp_show;
   int          cyc;
   string       scen;

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({an, seg, dp} !== e.val) begin
            errors++;
            $display("FAIL %s: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                     e.name, an, seg, dp, e.val[15:8], e.val[7:1], e.val[0]);
         end
      end
   end

   task automatic set_view(input logic [55:0] segs, input logic [7:0] mask, input logic [7:0] lz_show);
      exp_segs = segs;
      exp_mask = mask;
`ifdef SEG7_LZ_BLANK_EN
      exp_show = lz_show;
`else
      exp_show = 8'hFF;
`endif
   endtask

   task automatic step(input logic r, input logic ld, input logic [31:0] d, input logic [7:0] dpi);
      exp_t e;
      int   dv;
      int   ix;
      @(negedge clk);
      rst     = r;
      load    = ld;
      data_in = d;
      dp_in   = dpi;
      e.name  = scen;
      if (r) begin
         e.val = {8'hFF, 7'h7F, 1'b1};
         cyc   = 0;
      end else begin
         dv = cyc % RDIV;
         ix = (cyc / RDIV) % 8;
         if (dv < BLANK || !exp_show[ix])
            e.val = {8'hFF, 7'h7F, 1'b1};
         else
            e.val = {~(8'b1 << ix), exp_segs[7*ix +: 7], ~exp_mask[ix]};
         cyc++;
      end
      exp_q.push_back(e);
      @(posedge clk);
   endtask

   task automatic idle(input int n, input logic [31:0] d);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, d, 8'h00);
   endtask

   localparam logic [55:0] ALL_ZERO = {8{7'h40}};

   initial begin
      rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; cyc = 0;
      set_view(ALL_ZERO, 8'h00, 8'h01);

      scen = "reset";
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 8'h00);
      scen = "first_active";
      idle(2, 32'h0);

      scen = "full_scan";
      step(1'b1, 1'b0, 32'h0, 8'h00);
      step(1'b0, 1'b1, 32'h89AB_CDEF, 8'h00);
      set_view({7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'h00, 8'hFF);
      idle(33, 32'h0);

      scen = "load_hold";
      step(1'b1, 1'b0, 32'h0, 8'h00);
      step(1'b0, 1'b1, 32'h1, 8'h00);
      set_view({{7{7'h40}}, 7'h79}, 8'h00, 8'h01);
      idle(12, 32'h2);

      scen = "decimal_point";
      step(1'b0, 1'b1, 32'h1, 8'h04);
      set_view({{7{7'h40}}, 7'h79}, 8'h04, 8'h05);
      idle(32, 32'h0);

      scen = "rst_over_load";
      step(1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF);
      set_view(ALL_ZERO, 8'h00, 8'h01);
      idle(32, 32'h0);

      scen = "mid_scan_rst";
      step(1'b1, 1'b0, 32'h0, 8'h00);
      step(1'b0, 1'b1, 32'h89AB_CDEF, 8'h00);
      set_view({7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'h00, 8'hFF);
      idle(21, 32'h0);
      step(1'b1, 1'b0, 32'h0, 8'h00);
      set_view(ALL_ZERO, 8'h00, 8'h01);
      idle(6, 32'h0);

`ifdef SEG7_LZ_BLANK_EN
      scen = "lz_a30";
      step(1'b1, 1'b0, 32'h0, 8'h00);
      step(1'b0, 1'b1, 32'h0000_0A30, 8'h00);
      set_view({{5{7'h40}}, 7'h08, 7'h30, 7'h40}, 8'h00, 8'h07);
      idle(32, 32'h0);
      scen = "lz_zero";
      step(1'b0, 1'b1, 32'h0, 8'h00);
      set_view(ALL_ZERO, 8'h00, 8'h01);
      idle(32, 32'h0);
`endif

      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Time-multiplexed eight-digit seven-segment driver that sits downstream of the CPU board top level. It captures a 32-bit result word (ALU result or memory read data) and displays it as eight hexadecimal digits on the board's common-anode display. It replaces the byte-at-a-time LED view with a full-word view, scanning one digit per refresh slot with an anti-ghosting blank interval.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYCLES < REFRESH_DIV.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  32  word to display; digit 0 = data_in[3:0], digit 7 = data_in[31:28].
- load  input  1  when high at a rising edge, data_in and dp_in are captured into the shadow registers.
- dp_in  input  8  per-digit decimal point request; bit i lights the point of digit i.
- an  output  8  anode enables, active low, one-hot low during the active part of a slot.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.

## Operation
- Shadow registers: word_r[31:0] and dp_r[7:0]. Written only when load = 1; otherwise held. Continuous load means the shadow tracks the inputs every cycle.
- Slot counter div counts 0..REFRESH_DIV-1 and wraps to 0. Digit index idx[2:0] increments when div = REFRESH_DIV-1 and wraps from 7 to 0.
- Blank phase (div < BLANK_CYCLES): an = 8'hFF, seg = 7'h7F, dp = 1.
- Active phase: an = ~(8'b1 << idx), seg = hexdecode(word_r[4*idx+3 -: 4]), dp = ~dp_r[idx].
- Hex decode, active low: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- Reset values: word_r = 0, dp_r = 0, div = 0, idx = 0, an = 8'hFF, seg = 7'h7F, dp = 1.
- rst has priority over load in the same cycle. Reset asserted mid-slot or mid-scan returns all state to its reset values at that edge. No partial slot survives reset.

## Timing
- an, seg and dp are registered and computed from the div, idx and shadow values present before the edge. Outputs therefore lag internal state by exactly one cycle.
- A load sampled at edge t updates the shadow at edge t. The new value is visible on seg at edge t+1 if its digit is currently active.
- After reset deassertion, the first edge with an ≠ 8'hFF is edge BLANK_CYCLES+1, showing digit 0. With BLANK_CYCLES = 0 this is edge 1.
- Full scan period = 8 × REFRESH_DIV cycles. Each digit is active for REFRESH_DIV − BLANK_CYCLES cycles per scan.
- idx and div wrap silently; there is no overflow or status output.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero suppression.
  - Digits above the highest nonzero nibble of word_r are treated as blank for their whole slot (an = 8'hFF, seg = 7'h7F, dp = 1), unless that digit's dp_r bit is set.
  - Digit 0 is always shown, so word_r = 0 displays a single "0".
  - Slot timing is unchanged.
- SEG7_LZ_BLANK_EN undefined: all eight digits are always shown, including leading zeros.

## Test plan
Bench parameters for all scenarios: REFRESH_DIV = 4, BLANK_CYCLES = 1.
- Reset: hold rst for 3 cycles -> an = FF, seg = 7F, dp = 1. After release, the first active output is an = FE, seg = 40.
- Full scan: load data_in = 32'h89AB_CDEF for one cycle -> over 32 cycles, the digits 0..7 show seg 0E, 06, 21, 46, 03, 08, 10, 00 with an FE, FD, FB, F7, EF, DF, BF, 7F. Each digit is active for 3 cycles after 1 blank cycle.
- Load hold: load data_in = 32'h1, then change data_in to 32'h2 with load = 0 -> digit 0 keeps showing 79 (the "1").
- Decimal point: load dp_in = 8'h04 -> dp = 0 only while an = FB.
- Reset priority and mid-scan reset:
  - rst and load with data_in = 32'hFFFF_FFFF in the same cycle -> word_r stays 0.
  - rst asserted while idx = 5 -> next output is an = FF, followed by a restart at digit 0.
- With SEG7_LZ_BLANK_EN: load 32'h0000_0A30 -> digits 3..7 stay an = FF for their whole slots; digits 0..2 show 40, 30, 08. Loading 32'h0 shows only digit 0 = 40.
